// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants and FSM state type for the instruction-memory loader.
package imem_loader_pkg;
  localparam int ADDR_W_DEFAULT = 8;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [1:0] {IDLE, RECV, WRITE, FINISH} loaderState_e;
endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: collects program bytes MSB-first into a 32-bit instruction word.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic        full
);
  logic [1:0] idx;
  always_ff @(posedge clk)
    if (rst || clear) begin
      idx  <= '0;
      word <= '0;
    end else if (load) begin
      idx  <= idx + 2'd1;
      word <= {word[23:0], byteIn};
    end
  // full flags that the next accepted byte completes the word
  assign full = idx == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams program bytes into instruction memory while holding the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done
);
  localparam logic [63:0] DEPTH = 64'd1 << ADDR_W;
  loaderState_e state;
  logic [ADDR_W-1:0] wordIdx, lastIdx;
  logic zeroDone, xfer, full, accept;
  assign accept     = state == IDLE && start && len != '0;
  assign byte_ready = state == RECV && !rst;
  assign mem_we     = state == WRITE && !rst;
  assign xfer       = byte_valid && byte_ready;
  assign busy       = state == RECV || state == WRITE;
  assign cpu_hold   = busy;
  assign done       = state == FINISH || zeroDone;
  byte_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .load   (xfer),
    .byteIn (byte_data),
    .word   (mem_wdata),
    .full   (full)
  );
  // lastIdx holds the final word index, so oversize lengths clamp to the memory depth
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      wordIdx  <= '0;
      lastIdx  <= '0;
      mem_addr <= '0;
      zeroDone <= 1'b0;
    end else begin
      zeroDone <= state == IDLE && start && len == '0;
      case (state)
        IDLE:
          if (accept) begin
            state   <= RECV;
            wordIdx <= '0;
            lastIdx <= 64'(len) > DEPTH ? '1 : ADDR_W'(len - LEN_W'(1));
          end
        RECV:
          if (xfer && full) begin
            state    <= WRITE;
            mem_addr <= 32'({wordIdx, 2'b00});
          end
        WRITE:
          if (wordIdx == lastIdx) state <= FINISH;
          else begin
            wordIdx <= wordIdx + ADDR_W'(1);
            state   <= RECV;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench comparing loader writes to a byte-stream model.
module tb_imem_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, byte_valid = 1'b0;
  logic [8:0] len = '0;
  logic [7:0] byte_data = '0;
  logic byte_ready, mem_we, cpu_hold, busy, done;
  logic [31:0] mem_addr, mem_wdata;
  logic sStart = 1'b0, sValid = 1'b0;
  logic [4:0] sLen = '0;
  logic [7:0] sData = '0;
  logic sReady, sWe, sHold, sBusy, sDone;
  logic [31:0] sAddr, sWdata;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done)
  );
  imem_loader #(.ADDR_W(2), .LEN_W(5)) dutSmall (
    .clk(clk), .rst(rst), .start(sStart), .len(sLen), .byte_valid(sValid),
    .byte_data(sData), .byte_ready(sReady), .mem_we(sWe), .mem_addr(sAddr),
    .mem_wdata(sWdata), .cpu_hold(sHold), .busy(sBusy), .done(sDone)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t wq[$], swq[$];
  int doneQ[$];
  int sDoneCnt = 0, rdyWe = 0, busySeen = 0, startCyc = 0;
  logic [7:0] progQ[$], srcQ[$];
  int total = 0, bad = 0;

  always @(negedge clk) begin
    if (mem_we) wq.push_back('{cyc - startCyc, mem_addr, mem_wdata});
    if (done) doneQ.push_back(cyc - startCyc);
    if (mem_we && byte_ready) rdyWe++;
    if (busy) busySeen++;
    if (sWe) swq.push_back('{cyc, sAddr, sWdata});
    if (sDone) sDoneCnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic randProg(input int n);
    progQ.delete();
    for (int i = 0; i < n; i++) progQ.push_back(8'($urandom));
  endtask

  task automatic startLoad(input int l);
    start = 1'b1;
    len = 9'(l);
    startCyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int mode, input int maxCyc, input int restartAt);
    int n = 0;
    logic take;
    while (srcQ.size() > 0 && n < maxCyc) begin
      byte_valid = mode == 0 ? 1'b1 : mode == 1 ? ~n[0] : 1'($urandom_range(0, 1));
      byte_data = srcQ[0];
      if (n == restartAt) begin
        start = 1'b1;
        len = 9'd1;
      end else start = 1'b0;
      #1 take = byte_valid && byte_ready;
      @(posedge clk);
      if (take) void'(srcQ.pop_front());
      @(negedge clk);
      n++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    check("feedBudget", 64'(srcQ.size()), 0);
  endtask

  task automatic loadProg(input int l, input int mode, input int restartAt);
    srcQ = progQ;
    wq.delete();
    doneQ.delete();
    startLoad(l);
    feed(mode, 200, restartAt);
    repeat (3) @(negedge clk);
  endtask

  // model: word i is bytes 4i..4i+3 MSB-first at byte address 4i, word count clamped to 256
  task automatic expectWrites(input string tag, input int l);
    int n = l < 256 ? l : 256;
    check({tag, ".cnt"}, 64'(wq.size()), 64'(n));
    for (int i = 0; i < n; i++)
      if (i < wq.size()) begin
        check({tag, ".addr"}, wq[i].a, 64'(4 * i));
        check({tag, ".data"}, wq[i].d,
              {progQ[4*i], progQ[4*i+1], progQ[4*i+2], progQ[4*i+3]});
      end
    check({tag, ".done"}, 64'(doneQ.size()), 1);
    check({tag, ".hold"}, cpu_hold, 0);
  endtask

  initial begin
    logic take;
    int sCnt;
    repeat (3) @(negedge clk);
    check("rstCtl", {byte_ready, mem_we, cpu_hold, busy, done}, 0);
    check("rstAddr", mem_addr, 0);
    check("rstData", mem_wdata, 0);
    rst = 1'b0;

    progQ = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h07};
    loadProg(2, 0, -1);
    check("b2b.cnt", 64'(wq.size()), 2);
    if (wq.size() == 2) begin
      check("b2b.cyc0", 64'(wq[0].c), 5);
      check("b2b.addr0", wq[0].a, 32'h0);
      check("b2b.data0", wq[0].d, 32'h20010005);
      check("b2b.cyc1", 64'(wq[1].c), 10);
      check("b2b.addr1", wq[1].a, 32'h4);
      check("b2b.data1", wq[1].d, 32'h20020007);
    end
    check("b2b.doneCnt", 64'(doneQ.size()), 1);
    if (doneQ.size() > 0) check("b2b.doneCyc", 64'(doneQ[0]), 11);
    check("b2b.hold", cpu_hold, 0);

    randProg(4);
    loadProg(1, 1, -1);
    expectWrites("alt", 1);

    wq.delete();
    doneQ.delete();
    busySeen = 0;
    startLoad(0);
    repeat (3) @(negedge clk);
    check("len0.doneCnt", 64'(doneQ.size()), 1);
    if (doneQ.size() > 0) check("len0.doneCyc", 64'(doneQ[0]), 1);
    check("len0.we", 64'(wq.size()), 0);
    check("len0.busy", 64'(busySeen), 0);

    randProg(8);
    srcQ = progQ[0:1];
    wq.delete();
    startLoad(2);
    feed(0, 50, -1);
    rst = 1'b1;
    @(negedge clk);
    check("midRst.ctl", {byte_ready, mem_we, cpu_hold, busy, done}, 0);
    check("midRst.addr", mem_addr, 0);
    check("midRst.data", mem_wdata, 0);
    check("midRst.we", 64'(wq.size()), 0);
    rst = 1'b0;
    randProg(4);
    loadProg(1, 2, -1);
    expectWrites("afterRst", 1);

    randProg(12);
    loadProg(3, 2, 6);
    expectWrites("restart", 3);

    repeat (6) begin
      int l = $urandom_range(1, 4);
      randProg(4 * l);
      loadProg(l, $urandom_range(0, 2), -1);
      expectWrites("rand", l);
    end

    sDoneCnt = 0;
    swq.delete();
    sLen = 5'd9;
    sStart = 1'b1;
    @(negedge clk);
    sStart = 1'b0;
    sCnt = 0;
    sValid = 1'b1;
    for (int n = 0; n < 120; n++) begin
      sData = 8'(sCnt);
      #1 take = sValid && sReady;
      @(posedge clk);
      if (take) sCnt++;
      @(negedge clk);
    end
    sValid = 1'b0;
    check("sat.cnt", 64'(swq.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < swq.size()) begin
        check("sat.addr", swq[i].a, 64'(4 * i));
        check("sat.data", swq[i].d, {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)});
      end
    check("sat.bytes", 64'(sCnt), 16);
    check("sat.done", 64'(sDoneCnt), 1);
    check("sat.busy", sBusy, 0);

    check("readyInWrite", 64'(rdyWe), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
